uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_crc_pkg.sv | 31 +++
 rtl/crc8_serial.sv | 37 +++
 rtl/uart_tx_scheduler.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_crc_pkg.sv
// Shared definitions for the UART transmit scheduler: state encoding,
// default CRC-8 parameters, busy-timeout default and the captured-frame
// payload.
package uart_crc_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned STATE_W = 3;

  // Default CRC-8 generator (implicit x^8) and per-frame seed
  localparam logic [DATA_W-1:0] CRC_POLY_DEFAULT = 8'h07;
  localparam logic [DATA_W-1:0] CRC_INIT_DEFAULT = 8'h00;

  // Default number of cycles to wait for the transmitter to report busy
  localparam int unsigned BUSY_TIMEOUT_DEFAULT = 16;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_CRC       = 3'd1;
  localparam logic [STATE_W-1:0] ST_START     = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT_BUSY = 3'd3;
  localparam logic [STATE_W-1:0] ST_WAIT_DONE = 3'd4;

  // Byte owned by the current frame plus its bookkeeping
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              id;
    logic              inject;
  } frame_t;

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 engine, MSB first, no reflection, no final XOR.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (register -> 0)
//   load         : seed the register with INIT
//   step         : shift one message bit (din) into the register
//   din          : current message bit
//   crc_out      : CRC register contents
module crc8_serial
  import uart_crc_pkg::*;
#(
  parameter logic [DATA_W-1:0] POLY = CRC_POLY_DEFAULT,
  parameter logic [DATA_W-1:0] INIT = CRC_INIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic              din,
  output logic [DATA_W-1:0] crc_out
);

  logic feedback;

  assign feedback = crc_out[DATA_W-1] ^ din;

  // Load has priority over step
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_out <= '0;
    end else if (load) begin
      crc_out <= INIT;
    end else if (step) begin
      crc_out <= {crc_out[DATA_W-2:0], 1'b0} ^ (feedback ? POLY : '0);
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Two-requester round-robin scheduler feeding a UART transmitter. Each
// accepted byte gets a bit-serial CRC-8, a one-cycle tx_start, then the
// scheduler waits for the transmitter busy/idle handshake (with timeout).
// Optional build macro: UART_CRC_ERR_INJECT_EN adds crc_err_inject, which
// flips tx_crc bit 0 for the frame whose handshake sampled it high.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   crc_err_inject        : (macro only) corrupt CRC of the accepted frame
//   reqN_valid/data/ready : requester handshakes; ready is combinational
//   tx_data, tx_crc       : byte and its CRC, stable from START to IDLE
//   tx_start              : one-cycle transmit start pulse
//   tx_busy               : transmitter busy flag
//   sched_busy            : scheduler not idle
//   grant_id              : requester owning the current frame
//   timeout_err           : one-cycle pulse when tx_busy never arrived
module uart_tx_scheduler
  import uart_crc_pkg::*;
#(
  parameter logic [DATA_W-1:0] CRC_POLY     = CRC_POLY_DEFAULT,
  parameter logic [DATA_W-1:0] CRC_INIT     = CRC_INIT_DEFAULT,
  parameter int unsigned       BUSY_TIMEOUT = BUSY_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef UART_CRC_ERR_INJECT_EN
  input  logic              crc_err_inject,
`endif
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] tx_crc,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              sched_busy,
  output logic              grant_id,
  output logic              timeout_err
);

  localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam int unsigned BIT_W = 3;

  state_t           state, state_next;
  logic [CNT_W-1:0] to_cnt, to_cnt_next;
  logic [BIT_W-1:0] bit_idx, bit_idx_next;
  logic             last_grant, last_grant_next;
  frame_t           frame, frame_next;
  logic             tx_start_next, timeout_next, sched_busy_next;
  logic             win1, handshake, inj_sample;
  logic             crc_load, crc_step, crc_din;
  logic [DATA_W-1:0] crc_raw;

`ifdef UART_CRC_ERR_INJECT_EN
  assign inj_sample = crc_err_inject;
`else
  assign inj_sample = 1'b0;
`endif

  // Round robin: requester 1 wins alone, or on a tie when 0 was granted last
  assign win1       = req1_valid & (~req0_valid | ~last_grant);
  assign req0_ready = reset_n & (state == ST_IDLE) & req0_valid & ~win1;
  assign req1_ready = reset_n & (state == ST_IDLE) & win1;
  assign handshake  = req0_ready | req1_ready;

  // Message bits are fed MSB first
  assign crc_din = frame.data[BIT_W'(7) - bit_idx];

  crc8_serial #(
    .POLY (CRC_POLY),
    .INIT (CRC_INIT)
  ) u_crc (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (crc_load),
    .step    (crc_step),
    .din     (crc_din),
    .crc_out (crc_raw)
  );

  assign tx_data  = frame.data;
  assign grant_id = frame.id;
  assign tx_crc   = crc_raw ^ {{(DATA_W-1){1'b0}}, frame.inject};

  // Next-state and next-output logic
  always_comb begin
    state_next      = state;
    to_cnt_next     = to_cnt;
    bit_idx_next    = bit_idx;
    last_grant_next = last_grant;
    frame_next      = frame;
    timeout_next    = 1'b0;
    crc_load        = 1'b0;
    crc_step        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (handshake) begin
          frame_next.data   = win1 ? req1_data : req0_data;
          frame_next.id     = win1;
          frame_next.inject = inj_sample;
          crc_load          = 1'b1;
          bit_idx_next      = '0;
          state_next        = ST_CRC;
        end
      end
      ST_CRC: begin
        crc_step     = 1'b1;
        bit_idx_next = bit_idx + BIT_W'(1);
        if (bit_idx == BIT_W'(7)) begin
          state_next = ST_START;
        end
      end
      ST_START: begin
        to_cnt_next = '0;
        state_next  = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = ST_WAIT_DONE;
        end else if (to_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
          state_next      = ST_IDLE;
          timeout_next    = 1'b1;
          last_grant_next = frame.id;
        end else begin
          to_cnt_next = to_cnt + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          state_next      = ST_IDLE;
          last_grant_next = frame.id;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    tx_start_next   = (state_next == ST_START);
    sched_busy_next = (state_next != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      to_cnt      <= '0;
      bit_idx     <= '0;
      last_grant  <= 1'b1;
      frame       <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      sched_busy  <= 1'b0;
    end else begin
      state       <= state_next;
      to_cnt      <= to_cnt_next;
      bit_idx     <= bit_idx_next;
      last_grant  <= last_grant_next;
      frame       <= frame_next;
      tx_start    <= tx_start_next;
      timeout_err <= timeout_next;
      sched_busy  <= sched_busy_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: a frame-level reference model
// checks every output each cycle; directed scenarios add literal checks.
module tb_uart_tx_scheduler;

  localparam logic [7:0] POLY = 8'h07;
  localparam logic [7:0] INIT = 8'h00;
  localparam int         BT   = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       tx_busy = 1'b0;
  logic       req0_ready, req1_ready, tx_start, sched_busy, grant_id, timeout_err;
  logic [7:0] tx_data, tx_crc;
  logic       inj_in;
`ifdef UART_CRC_ERR_INJECT_EN
  logic       crc_err_inject = 1'b0;
  assign inj_in = crc_err_inject;
`else
  assign inj_in = 1'b0;
`endif

  uart_tx_scheduler #(
    .CRC_POLY     (POLY),
    .CRC_INIT     (INIT),
    .BUSY_TIMEOUT (BT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
`ifdef UART_CRC_ERR_INJECT_EN
    .crc_err_inject (crc_err_inject),
`endif
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .tx_data     (tx_data),
    .tx_crc      (tx_crc),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .sched_busy  (sched_busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference CRC: whole-byte form, seed XOR data then 8 shifts
  function automatic logic [7:0] crc8_ref(input logic [7:0] d);
    logic [7:0] c;
    c = INIT ^ d;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ POLY) : (c << 1);
    return c;
  endfunction

  // ---------------- stimulus driver and transmitter stand-in ----------------
  logic [7:0] q0[$], q1[$];
  bit         i0[$];
  bit         xmit_en = 1'b1;
  int         xt = -1;
  bit         hs0, hs1, st_seen;
  int         st_cyc[$], hs_log[$], to_log[$];
  logic [7:0] st_data[$], st_crc[$];
  logic       st_grant[$];

  always begin
    @(negedge clk);
    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;
    if (hs0 || hs1) hs_log.push_back(cyc);
    st_seen = tx_start;
    if (tx_start) begin
      st_cyc.push_back(cyc);
      st_data.push_back(tx_data);
      st_crc.push_back(tx_crc);
      st_grant.push_back(grant_id);
    end
    if (timeout_err) to_log.push_back(cyc);
    @(posedge clk);
    #1;
    if (hs0 && q0.size() > 0) begin void'(q0.pop_front()); void'(i0.pop_front()); end
    if (hs1 && q1.size() > 0) void'(q1.pop_front());
    if (!reset_n) xt = -1;
    else if (st_seen) xt = 0;
    else if (xt >= 0) xt++;
    if (xt >= 6) xt = -1;
    tx_busy    = xmit_en && xt >= 2 && xt < 6;
    req0_valid = q0.size() > 0;
    req0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
    req1_valid = q1.size() > 0;
    req1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
`ifdef UART_CRC_ERR_INJECT_EN
    crc_err_inject = (i0.size() > 0) ? i0[0] : 1'b0;
`endif
  end

  // ---------------- frame-level reference model + per-cycle compare ----------------
  bit         m_act = 1'b0, m_last = 1'b1, m_grant = 1'b0, m_to = 1'b0, m_seen = 1'b0;
  int         m_hs = 0;
  logic [7:0] m_data = 8'h00, m_crc = 8'h00;
  int         age;
  logic       e_r0, e_r1, e_st, e_sb, e_to;

  always @(negedge clk) begin
    if (!reset_n) begin
      check1("rst_req0_ready", req0_ready, 1'b0);
      check1("rst_req1_ready", req1_ready, 1'b0);
      check1("rst_tx_start", tx_start, 1'b0);
      check1("rst_sched_busy", sched_busy, 1'b0);
      check1("rst_timeout_err", timeout_err, 1'b0);
      check1("rst_grant_id", grant_id, 1'b0);
      check8("rst_tx_data", tx_data, 8'h00);
      check8("rst_tx_crc", tx_crc, 8'h00);
      m_act = 0; m_last = 1; m_grant = 0; m_to = 0; m_seen = 0;
      m_data = 8'h00; m_crc = 8'h00;
    end else begin
      age = cyc - m_hs;
      if (!m_act) begin
        e_r0 = req0_valid && (!req1_valid || m_last);
        e_r1 = req1_valid && (!req0_valid || !m_last);
        e_st = 0; e_sb = 0; e_to = m_to;
      end else begin
        e_r0 = 0; e_r1 = 0; e_st = (age == 9); e_sb = 1; e_to = 0;
      end
      check1("req0_ready", req0_ready, e_r0);
      check1("req1_ready", req1_ready, e_r1);
      check1("tx_start", tx_start, e_st);
      check1("sched_busy", sched_busy, e_sb);
      check1("timeout_err", timeout_err, e_to);
      check1("grant_id", grant_id, m_grant);
      check8("tx_data", tx_data, m_data);
      if (!(m_act && age < 9)) check8("tx_crc", tx_crc, m_crc);
      m_to = 0;
      if (!m_act) begin
        if (e_r0 || e_r1) begin
          m_act = 1; m_hs = cyc; m_seen = 0; m_grant = e_r1;
          m_data = e_r1 ? req1_data : req0_data;
          m_crc = crc8_ref(m_data) ^ {7'b0, inj_in};
        end
      end else if (age >= 10) begin
        if (!m_seen) begin
          if (tx_busy) m_seen = 1;
          else if (age == 9 + BT) begin m_act = 0; m_to = 1; m_last = m_grant; end
        end else if (!tx_busy) begin
          m_act = 0; m_last = m_grant;
        end
      end
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic push0(input logic [7:0] d, input bit inj);
    q0.push_back(d);
    i0.push_back(inj);
  endtask

  task automatic wait_quiet(input string tag, input int maxc);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!(q0.size() == 0 && q1.size() == 0 && !m_act) && n < maxc);
    if (!(q0.size() == 0 && q1.size() == 0 && !m_act)) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", tag, n);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input int idx, input string tag, input logic [7:0] d,
                             input logic [7:0] c, input logic g);
    if (idx < st_cyc.size()) begin
      check8({tag, "_data"}, st_data[idx], d);
      check8({tag, "_crc"}, st_crc[idx], c);
      check1({tag, "_grant"}, st_grant[idx], g);
    end else begin
      n_cmp++; n_bad++;
      $display("FAIL %s_missing: frames seen %0d required %0d", tag, st_cyc.size(), idx + 1);
    end
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    repeat (n) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int b, h, t, n;
    do_reset(3);
    @(negedge clk);
    check1("idle_sched_busy", sched_busy, 1'b0);
    check8("idle_tx_data", tx_data, 8'h00);
    @(posedge clk); #1;

    // Single requester 0
    b = st_cyc.size(); h = hs_log.size();
    push0(8'h31, 1'b0);
    wait_quiet("single", 100);
    check_frame(b, "single", 8'h31, 8'h97, 1'b0);
    if (b < st_cyc.size() && h < hs_log.size())
      check_int("start_latency", st_cyc[b] - hs_log[h], 9);
    else begin n_cmp++; n_bad++; $display("FAIL start_latency: no handshake/start logged"); end

    // Simultaneous from reset: req0 first, req1 back-to-back
    do_reset(2);
    b = st_cyc.size(); h = hs_log.size();
    push0(8'hFF, 1'b0);
    q1.push_back(8'h5A);
    wait_quiet("tie", 200);
    check_frame(b, "tie_first", 8'hFF, 8'hF3, 1'b0);
    check_frame(b + 1, "tie_second", 8'h5A, 8'h81, 1'b1);
    if (b < st_cyc.size() && h + 1 < hs_log.size())
      check_int("b2b_gap", hs_log[h + 1] - st_cyc[b], 8);
    else begin n_cmp++; n_bad++; $display("FAIL b2b_gap: second handshake not logged"); end

    // Four frames with both requesters loaded: 0,1,0,1
    b = st_cyc.size();
    push0(8'h31, 1'b0); push0(8'hFF, 1'b0);
    q1.push_back(8'h5A); q1.push_back(8'h44);
    wait_quiet("rr4", 300);
    check_frame(b,     "rr4_f0", 8'h31, 8'h97, 1'b0);
    check_frame(b + 1, "rr4_f1", 8'h5A, 8'h81, 1'b1);
    check_frame(b + 2, "rr4_f2", 8'hFF, 8'hF3, 1'b0);
    check_frame(b + 3, "rr4_f3", 8'h44, 8'hDB, 1'b1);

    // Transmitter never busy: timeout
    xmit_en = 1'b0;
    b = st_cyc.size(); t = to_log.size();
    q1.push_back(8'h31);
    wait_quiet("tmo", 200);
    check_frame(b, "tmo", 8'h31, 8'h97, 1'b1);
    if (b < st_cyc.size() && t < to_log.size())
      check_int("timeout_delay", to_log[t] - st_cyc[b], BT + 1);
    else begin n_cmp++; n_bad++; $display("FAIL timeout_delay: no timeout pulse logged"); end
    xmit_en = 1'b1;

    // Reset while waiting for transmitter done
    b = st_cyc.size();
    q1.push_back(8'h5A);
    n = 0;
    while (st_cyc.size() <= b && n < 100) begin @(posedge clk); n++; end
    if (st_cyc.size() <= b) begin n_cmp++; n_bad++; $display("FAIL midrst_start: no tx_start within %0d cycles", n); end
    repeat (3) @(posedge clk);
    #1;
    check1("pre_rst_sched_busy", sched_busy, 1'b1);
    check1("pre_rst_tx_busy", tx_busy, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check1("midrst_sched_busy", sched_busy, 1'b0);
    check1("midrst_grant_id", grant_id, 1'b0);
    check8("midrst_tx_data", tx_data, 8'h00);
    check8("midrst_tx_crc", tx_crc, 8'h00);
    check1("midrst_tx_start", tx_start, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    push0(8'h44, 1'b0);
    q1.push_back(8'h31);
    wait_quiet("postrst", 200);
    check_frame(b + 1, "postrst_f0", 8'h44, 8'hDB, 1'b0);
    check_frame(b + 2, "postrst_f1", 8'h31, 8'h97, 1'b1);

`ifdef UART_CRC_ERR_INJECT_EN
    // CRC corruption affects only the flagged frame
    b = st_cyc.size();
    push0(8'h00, 1'b1);
    push0(8'h00, 1'b0);
    wait_quiet("inject", 200);
    check_frame(b,     "inject_on",  8'h00, 8'h01, 1'b0);
    check_frame(b + 1, "inject_off", 8'h00, 8'h00, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
